forward_ctrl: RTL

Forwarding and load-use hazard controller for the ARM 5-stage pipeline. Tracks the destination register, write-back enable and load flag of each in-flight instruction in the EXE, MEM and WB stages. Produces registered forwarding selects for the two EXE-stage operand muxes, plus a combinational stall request for IF/ID. Sits beside the ID/EXE pipeline register and drives the `sel` inputs of both operand 3-to-1 muxes.

---
 rtl/forward_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/forward_ctrl.sv
// forward_ctrl: forwarding-select and load-use hazard controller for the
// 5-stage ARM pipeline. Tracks {valid, wb_en, dest, mem_read} for the
// instructions in EXE, MEM and WB, registers the EXE operand-mux selects at
// the ID->EXE edge and raises a combinational stall for IF/ID.
//
// Optional feature macro: FORWARDING_EN
//   defined   : selects forward from MEM/WB, stall only on load-use.
//   undefined : selects are always FROM_ID, stall on any RAW dependency on a
//               producer still in EXE or MEM.
//
// Handshake: none; the block follows the pipeline. freeze holds every
// register (slots and selects) and dominates flush/stall for state update,
// while o_stall keeps being evaluated combinationally.
//
// o_dbg_slots exposes the tracking slots as {exe, mem, wb}, each slot packed
// as {valid, wb_en, dest, mem_read}.
module forward_ctrl #(
  parameter int REG_ADDR_LEN = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_freeze,
  input  logic                    i_flush,
  input  logic                    i_id_valid,
  input  logic [REG_ADDR_LEN-1:0] i_id_src1,
  input  logic [REG_ADDR_LEN-1:0] i_id_src2,
  input  logic                    i_id_src1_used,
  input  logic                    i_id_src2_used,
  input  logic                    i_id_wb_en,
  input  logic [REG_ADDR_LEN-1:0] i_id_dest,
  input  logic                    i_id_mem_read,
  output logic [1:0]              o_sel_src1,
  output logic [1:0]              o_sel_src2,
  output logic                    o_stall,
  output logic [3*(REG_ADDR_LEN+3)-1:0] o_dbg_slots
);

  // Operand-mux select encodings shared with the EXE-stage muxes.
  localparam logic [1:0] FORW_SEL_FROM_ID  = 2'b00;
  localparam logic [1:0] FORW_SEL_FROM_WB  = 2'b01;
  localparam logic [1:0] FORW_SEL_FROM_MEM = 2'b10;

  typedef struct packed {
    logic                    valid;
    logic                    wb_en;
    logic [REG_ADDR_LEN-1:0] dest;
    logic                    mem_read;
  } slot_t;

  slot_t      r_exe;
  slot_t      r_mem;
  slot_t      r_wb;
  logic [1:0] r_sel_src1;
  logic [1:0] r_sel_src2;

  logic  w_m1_exe;
  logic  w_m2_exe;
  logic  w_m1_mem;
  logic  w_m2_mem;
  logic  w_hazard;
  logic  w_stall;
  logic  w_bubble;
  logic  [1:0] w_sel_src1;
  logic  [1:0] w_sel_src2;
  slot_t w_id_slot;

  // Source/producer matches against the EXE and MEM slots (pre-shift contents).
  always_comb begin
    w_m1_exe = i_id_src1_used && r_exe.valid && r_exe.wb_en && (i_id_src1 == r_exe.dest);
    w_m2_exe = i_id_src2_used && r_exe.valid && r_exe.wb_en && (i_id_src2 == r_exe.dest);
    w_m1_mem = i_id_src1_used && r_mem.valid && r_mem.wb_en && (i_id_src1 == r_mem.dest);
    w_m2_mem = i_id_src2_used && r_mem.valid && r_mem.wb_en && (i_id_src2 == r_mem.dest);
  end

  // Hazard detection and next-select computation; the youngest producer wins.
  always_comb begin
    w_sel_src1 = FORW_SEL_FROM_ID;
    w_sel_src2 = FORW_SEL_FROM_ID;
`ifdef FORWARDING_EN
    // Only a load in EXE cannot be forwarded in time: its data appears in MEM.
    w_hazard = r_exe.valid && r_exe.mem_read && r_exe.wb_en && (w_m1_exe || w_m2_exe);
    if (w_m1_exe)      w_sel_src1 = FORW_SEL_FROM_MEM;
    else if (w_m1_mem) w_sel_src1 = FORW_SEL_FROM_WB;
    if (w_m2_exe)      w_sel_src2 = FORW_SEL_FROM_MEM;
    else if (w_m2_mem) w_sel_src2 = FORW_SEL_FROM_WB;
`else
    // Without forwarding, wait until the producer reaches WB (register file
    // write-before-read covers it from there).
    w_hazard = w_m1_exe || w_m2_exe || w_m1_mem || w_m2_mem;
`endif
    w_stall  = i_id_valid && !i_flush && w_hazard;
    w_bubble = i_flush || w_stall || !i_id_valid;
    w_id_slot.valid    = 1'b1;
    w_id_slot.wb_en    = i_id_wb_en;
    w_id_slot.dest     = i_id_dest;
    w_id_slot.mem_read = i_id_mem_read;
  end

  // Slot shift and select registers; freeze holds everything, reset clears.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_exe      <= '0;
      r_mem      <= '0;
      r_wb       <= '0;
      r_sel_src1 <= FORW_SEL_FROM_ID;
      r_sel_src2 <= FORW_SEL_FROM_ID;
    end else if (!i_freeze) begin
      r_wb  <= r_mem;
      r_mem <= r_exe;
      if (w_bubble) begin
        r_exe      <= '0;
        r_sel_src1 <= FORW_SEL_FROM_ID;
        r_sel_src2 <= FORW_SEL_FROM_ID;
      end else begin
        r_exe      <= w_id_slot;
        r_sel_src1 <= w_sel_src1;
        r_sel_src2 <= w_sel_src2;
      end
    end
  end

  assign o_sel_src1  = r_sel_src1;
  assign o_sel_src2  = r_sel_src2;
  assign o_stall     = w_stall;
  assign o_dbg_slots = {r_exe, r_mem, r_wb};

endmodule
